mc_fork_scheduler: RTL and testbench

MC_FORK_SCHEDULER -- requirements
Module: mc_fork_scheduler

---
 rtl/mc_fork_scheduler.sv | 171 +++++++++++++++++
 tb/tb_mc_fork_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_fork_scheduler.sv
// Multicast fork scheduler: splits one multicast flit into per-direction sub-flits (L,S,E,N,W).
// Optional macro MC_RR_EN rotates the group search start on every accepted flit.
module mc_fork_scheduler #(
  parameter int DATASIZE  = 30,
  parameter int router_ID = 6
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic [4:0]          out_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                flit_done,
  output logic [7:0]          drop_cnt
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          pend_q, pend_d;
  logic [28:0]         flit_q, flit_d;
  logic [2:0]          base_q, base_d;
  logic [DATASIZE-1:0] data_q, data_d;
  logic [4:0]          dir_q, dir_d;
  logic                done_q, done_d;
  logic [7:0]          drop_q, drop_d;
  logic [2:0]          ptr_q;
  logic                accept;
  logic [4:0]          acc_mask, rem;
  logic [2:0]          sel;
  logic                unused_cfg;

  assign unused_cfg = (router_ID != 0);

  // dst_list bits belonging to each group: L0 S1 E2 N3 W4
  function automatic logic [15:0] grp_bits(input logic [2:0] g);
    case (g)
      3'd0:    return 16'h0010;
      3'd1:    return 16'h000F;
      3'd2:    return 16'h00E0;
      3'd3:    return 16'hFE00;
      default: return 16'h0100;
    endcase
  endfunction

  function automatic logic [4:0] pend_of(input logic [15:0] dst, input logic vld);
    logic [4:0] m;
    m = '0;
    for (int unsigned g = 0; g < 5; g++) begin
      m[g] = vld & (|(dst & grp_bits(3'(g))));
    end
    return m;
  endfunction

  function automatic logic [2:0] pick(input logic [4:0] mask, input logic [2:0] start);
    logic [2:0]  s;
    logic        found;
    int unsigned idx;
    s     = start;
    found = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = 32'(start) + k;
      if (idx >= 5) idx = idx - 5;
      if (!found && mask[3'(idx)]) begin
        s     = 3'(idx);
        found = 1'b1;
      end
    end
    return s;
  endfunction

  // f holds in_data[29:1]: header f[28:24], dst_list f[23:8], tag f[7:0]
  function automatic logic [29:0] subflit(input logic [28:0] f, input logic [2:0] g);
    return {f[28:24], f[23:8] & grp_bits(g), f[7:0], 1'b1};
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == ISSUE);
  assign out_data  = data_q;
  assign out_dir   = dir_q;
  assign flit_done = done_q;
  assign drop_cnt  = drop_q;
  assign accept    = in_valid & (state_q == IDLE);
  assign acc_mask  = pend_of(in_data[24:9], in_data[0]);

`ifdef MC_RR_EN
  logic [2:0] ptr_d;
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (ptr_q == 3'd4) ? '0 : ptr_q + 3'd1;
  end
  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    flit_d  = flit_q;
    base_d  = base_q;
    data_d  = data_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    rem     = pend_q & ~dir_q;
    sel     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          flit_d = in_data[29:1];
          base_d = ptr_q;
          if (acc_mask == '0) begin
            done_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            sel     = pick(acc_mask, ptr_q);
            pend_d  = acc_mask;
            data_d  = subflit(in_data[29:1], sel);
            dir_d   = 5'(1) << sel;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // pend_q still includes the group on the output; dir_q is its one-hot bit
        if (out_ready) begin
          pend_d = rem;
          if (rem == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sel    = pick(rem, base_q);
            data_d = subflit(flit_q, sel);
            dir_d  = 5'(1) << sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      flit_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      dir_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flit_q  <= flit_d;
      base_q  <= base_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_mc_fork_scheduler.sv
// Bench for mc_fork_scheduler: per-flit expected sub-flit list model plus directed literal checks.
// Honours MC_RR_EN when the build defines it.
module tb_mc_fork_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [29:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, flit_done;
  logic [29:0] out_data;
  logic [4:0]  out_dir;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  mc_fork_scheduler #(.DATASIZE(30), .router_ID(6)) dut (
    .rc_clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dir(out_dir), .out_valid(out_valid), .out_ready(out_ready),
    .flit_done(flit_done), .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: each accepted flit becomes a list of expected sub-flits
  typedef struct packed {logic [29:0] d; logic [4:0] dir;} sub_t;
  logic [15:0] gm [5] = '{16'h0010, 16'h000F, 16'h00E0, 16'hFE00, 16'h0100};
  sub_t        m_q[$];
  sub_t        m_s;
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_drop = 0;
  int          m_ptr = 0;
  int          m_g;
  logic [29:0] m_data = '0;
  logic [4:0]  m_dir = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 0; m_done = 0; m_drop = 0; m_ptr = 0; m_data = '0; m_dir = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (in_valid) begin
          for (int k = 0; k < 5; k++) begin
            m_g = (m_ptr + k) % 5;
            if (in_data[0] && ((in_data[24:9] & gm[m_g]) != 16'h0)) begin
              m_s.d   = {in_data[29:25], in_data[24:9] & gm[m_g], in_data[8:1], 1'b1};
              m_s.dir = 5'(1) << m_g;
              m_q.push_back(m_s);
            end
          end
`ifdef MC_RR_EN
          m_ptr = (m_ptr + 1) % 5;
`endif
          if (m_q.size() == 0) begin
            m_done = 1;
            if (m_drop < 255) m_drop++;
          end else m_busy = 1;
        end
      end else if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (m_busy) begin
        m_data = m_q[0].d;
        m_dir  = m_q[0].dir;
      end
    end
  end

  // ---------------- compare process plus transfer/done capture
  bit          chk_en = 0;
  int          cyc = 0;
  logic [4:0]  cap_dir[$];
  logic [29:0] cap_data[$];
  int          cap_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    #1;
    if (chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy);
      chk("out_data", out_data, m_data);
      chk("out_dir", out_dir, m_dir);
      chk("flit_done", flit_done, m_done);
      chk("drop_cnt", drop_cnt, m_drop);
      if (out_valid && out_ready) begin
        cap_dir.push_back(out_dir);
        cap_data.push_back(out_data);
        cap_cyc.push_back(cyc);
      end
      if (flit_done) done_cyc.push_back(cyc);
    end
  end

  task automatic clear_caps();
    cap_dir.delete(); cap_data.delete(); cap_cyc.delete(); done_cyc.delete();
  endtask

  task automatic send(input logic [29:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((out_valid || !in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (out_valid || !in_ready) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  localparam logic [29:0] F1   = {5'h15, 16'h0211, 8'hA5, 1'b1};
  localparam logic [29:0] F1_L = {5'h15, 16'h0010, 8'hA5, 1'b1};
  localparam logic [29:0] FALL = {5'h0A, 16'hFFFF, 8'h3C, 1'b1};

  logic [4:0] exp_rr [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1;
    #20 rst_n = 1'b1;
    @(negedge clk); #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dir", out_dir, 0);
    chk("rst_drop", drop_cnt, 0);

    // three sub-flits back to back: L, S, N, then flit_done
    out_ready = 1'b1;
    clear_caps();
    send(F1);
    wait_idle();
    chk("A_count", cap_dir.size(), 3);
    if (cap_dir.size() == 3) begin
      chk("A_dir0", cap_dir[0], 5'b00001);
      chk("A_dir1", cap_dir[1], 5'b00010);
      chk("A_dir2", cap_dir[2], 5'b01000);
      chk("A_dst0", cap_data[0][24:9], 16'h0010);
      chk("A_dst1", cap_data[1][24:9], 16'h0001);
      chk("A_dst2", cap_data[2][24:9], 16'h0200);
      chk("A_full0", cap_data[0], F1_L);
      chk("A_consec", cap_cyc[2] - cap_cyc[0], 2);
      chk("A_done_n", done_cyc.size(), 1);
      if (done_cyc.size() == 1) chk("A_done_cyc", done_cyc[0] - cap_cyc[2], 1);
    end

    // stall: first sub-flit held for 4 cycles
    out_ready = 1'b0;
    clear_caps();
    send(F1);
    #2;
    chk("B_hold_c1", out_data, F1_L);
    chk("B_ready_c1", in_ready, 0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) out_ready = 1'b1;
      #2;
      chk("B_hold", out_data, F1_L);
      chk("B_dir", out_dir, 5'b00001);
      chk("B_valid", out_valid, 1);
      chk("B_ready", in_ready, 0);
    end
    wait_idle();
    chk("B_count", cap_dir.size(), 3);
    if (cap_dir.size() == 3) chk("B_dir2", cap_dir[2], 5'b01000);

    // drops: empty dst_list, cleared valid flag, then saturation
    clear_caps();
    send({5'h15, 16'h0000, 8'hA5, 1'b1});
    wait_idle();
    chk("C_drop1", drop_cnt, 1);
    chk("C_done", done_cyc.size(), 1);
    chk("C_noissue", cap_dir.size(), 0);
    send({5'h15, 16'h0211, 8'hA5, 1'b0});
    wait_idle();
    chk("C_drop2", drop_cnt, 2);
    @(negedge clk);
    in_data  = {5'h01, 16'h0000, 8'h00, 1'b1};
    in_valid = 1'b1;
    repeat (256) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    chk("C_sat", drop_cnt, 255);
    chk("C_noissue2", cap_dir.size(), 0);

    // all groups, two flits: order depends on the start pointer rotation
    pulse_reset();
    clear_caps();
    send(FALL);
    wait_idle();
    send(FALL);
    wait_idle();
`ifdef MC_RR_EN
    exp_rr = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
`else
    exp_rr = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
`endif
    chk("D_count", cap_dir.size(), 10);
    if (cap_dir.size() == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("D_dir%0d", i), cap_dir[i], exp_rr[i]);
      chk("D_dstS", cap_data[1][24:9], 16'h000F);
      chk("D_dstN", cap_data[3][24:9], 16'hFE00);
      chk("D_dstE", cap_data[2][24:9], 16'h00E0);
    end

    // reset during the second sub-flit
    clear_caps();
    send(F1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("E_valid", out_valid, 0);
    chk("E_data", out_data, 0);
    chk("E_dir", out_dir, 0);
    chk("E_done", flit_done, 0);
    chk("E_drop", drop_cnt, 0);
    chk("E_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    done_cyc.delete();
    repeat (3) @(negedge clk);
    #2;
    chk("E_nodone", done_cyc.size(), 0);
    clear_caps();
    send(F1);
    wait_idle();
    chk("E_count", cap_dir.size(), 3);
    if (cap_dir.size() == 3) chk("E_dir0", cap_dir[0], 5'b00001);
    chk("E_done_n", done_cyc.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
